// File: rtl/writeback_sequencer.sv
// Writeback sequencer: selects the regfile port-3 write source (ALU result or
// cache load), drives WE3/AD3/WD3 and runs the variable-latency load handshake
// with the cache, stalling the issuing stage while a load is outstanding.
// Optional feature macro: PERF_CNT_EN adds a saturating stall-cycle counter
// on o_StallCount.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | accepting instructions; ALU results write back next cycle
// S_WAIT_MEM | load issued, waiting for MemValid or the timeout
module writeback_sequencer #(
  parameter int Data_Width = 32,
  parameter int Addr_Width = 5,
  parameter int TIMEOUT    = 16,
  parameter int CNT_Width  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_InstrValid,
  input  logic                  i_RegWrite,
  input  logic                  i_ResultSrc,
  input  logic [Addr_Width-1:0] i_Rd,
  input  logic [Data_Width-1:0] i_ALUResult,
  input  logic                  i_MemValid,
  input  logic [Data_Width-1:0] i_ReadData,
  output logic                  o_MemReq,
  output logic                  o_Stall,
  output logic                  o_SrcSel,
  output logic                  o_WE3,
  output logic [Addr_Width-1:0] o_AD3,
  output logic [Data_Width-1:0] o_WD3,
  output logic                  o_MemErr
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_Width-1:0]  o_StallCount
`endif
);

  // Wait counter only has to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_WAIT_MEM = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CW-1:0]         r_wait_cnt;
  logic [CW-1:0]         w_wait_cnt_next;
  logic [Addr_Width-1:0] r_rd_lat;
  logic [Addr_Width-1:0] w_rd_lat_next;
  logic                  r_regwrite_lat;
  logic                  w_regwrite_lat_next;
  logic                  r_we3;
  logic                  w_we3_next;
  logic [Addr_Width-1:0] r_ad3;
  logic [Addr_Width-1:0] w_ad3_next;
  logic [Data_Width-1:0] r_wd3;
  logic [Data_Width-1:0] w_wd3_next;
  logic                  r_srcsel;
  logic                  w_srcsel_next;
  logic                  r_memerr;
  logic                  w_memerr_next;
  logic                  w_mem_req;
  logic                  w_stall;

  // Next-state, combinational handshake outputs and next writeback values.
  always_comb begin
    w_state_next        = r_state;
    w_wait_cnt_next     = r_wait_cnt;
    w_rd_lat_next       = r_rd_lat;
    w_regwrite_lat_next = r_regwrite_lat;
    w_we3_next          = 1'b0;
    w_ad3_next          = r_ad3;
    w_wd3_next          = r_wd3;
    w_srcsel_next       = r_srcsel;
    w_memerr_next       = 1'b0;
    w_mem_req           = 1'b0;
    w_stall             = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_InstrValid) begin
          if (!i_ResultSrc) begin
            // x0 is hardwired zero: address/data still track, write is dropped
            w_we3_next    = i_RegWrite && (i_Rd != '0);
            w_ad3_next    = i_Rd;
            w_wd3_next    = i_ALUResult;
            w_srcsel_next = 1'b0;
          end else begin
            w_mem_req           = 1'b1;
            w_stall             = 1'b1;
            w_rd_lat_next       = i_Rd;
            w_regwrite_lat_next = i_RegWrite;
            w_wait_cnt_next     = '0;
            w_state_next        = S_WAIT_MEM;
          end
        end
      end
      S_WAIT_MEM: begin
        w_stall = !i_MemValid;
        if (i_MemValid) begin
          // A response in the final wait cycle still counts as on time.
          w_we3_next    = r_regwrite_lat && (r_rd_lat != '0);
          w_ad3_next    = r_rd_lat;
          w_wd3_next    = i_ReadData;
          w_srcsel_next = 1'b1;
          w_state_next  = S_IDLE;
        end else if (r_wait_cnt == CW'(TIMEOUT - 1)) begin
          w_memerr_next = 1'b1;
          w_state_next  = S_IDLE;
        end else begin
          w_wait_cnt_next = r_wait_cnt + CW'(1);
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State, load context and registered writeback port, synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_wait_cnt     <= '0;
      r_rd_lat       <= '0;
      r_regwrite_lat <= 1'b0;
      r_we3          <= 1'b0;
      r_ad3          <= '0;
      r_wd3          <= '0;
      r_srcsel       <= 1'b0;
      r_memerr       <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_wait_cnt     <= w_wait_cnt_next;
      r_rd_lat       <= w_rd_lat_next;
      r_regwrite_lat <= w_regwrite_lat_next;
      r_we3          <= w_we3_next;
      r_ad3          <= w_ad3_next;
      r_wd3          <= w_wd3_next;
      r_srcsel       <= w_srcsel_next;
      r_memerr       <= w_memerr_next;
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_Width-1:0] r_stall_cnt;

  // Count stalled cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_Width'(1);
    end
  end

  assign o_StallCount = r_stall_cnt;
`endif

  assign o_MemReq = w_mem_req;
  assign o_Stall  = w_stall;
  assign o_SrcSel = r_srcsel;
  assign o_WE3    = r_we3;
  assign o_AD3    = r_ad3;
  assign o_WD3    = r_wd3;
  assign o_MemErr = r_memerr;

endmodule

// File: tb/tb_writeback_sequencer.sv
// Self-checking bench for writeback_sequencer: expected writebacks are queued
// when stimulus is driven and compared when the registered port updates.
module tb_writeback_sequencer;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TO = 16;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_InstrValid;
  logic          i_RegWrite;
  logic          i_ResultSrc;
  logic [AW-1:0] i_Rd;
  logic [DW-1:0] i_ALUResult;
  logic          i_MemValid;
  logic [DW-1:0] i_ReadData;
  logic          o_MemReq;
  logic          o_Stall;
  logic          o_SrcSel;
  logic          o_WE3;
  logic [AW-1:0] o_AD3;
  logic [DW-1:0] o_WD3;
  logic          o_MemErr;
`ifdef PERF_CNT_EN
  logic [CW-1:0] o_StallCount;
`endif

  always #5 clk = ~clk;

  writeback_sequencer #(
    .Data_Width(DW), .Addr_Width(AW), .TIMEOUT(TO), .CNT_Width(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_InstrValid(i_InstrValid), .i_RegWrite(i_RegWrite),
    .i_ResultSrc(i_ResultSrc), .i_Rd(i_Rd), .i_ALUResult(i_ALUResult),
    .i_MemValid(i_MemValid), .i_ReadData(i_ReadData),
    .o_MemReq(o_MemReq), .o_Stall(o_Stall), .o_SrcSel(o_SrcSel),
    .o_WE3(o_WE3), .o_AD3(o_AD3), .o_WD3(o_WD3), .o_MemErr(o_MemErr)
`ifdef PERF_CNT_EN
    , .o_StallCount(o_StallCount)
`endif
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    logic          src;
    logic          err;
  } exp_t;

  exp_t          sb_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic          exp_stall;
  logic          exp_memreq;
  int            obs_stall_run;
  longint        m_stall_cnt;
  logic [AW-1:0] m_ad3;
  logic [DW-1:0] m_wd3;
  logic          m_src;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_wb(input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                         input logic src);
    exp_t e;
    m_ad3 = ad;
    m_wd3 = wd;
    m_src = src;
    e.we = we; e.ad = ad; e.wd = wd; e.src = src; e.err = 1'b0;
    sb_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.we = 1'b0; e.ad = m_ad3; e.wd = m_wd3; e.src = m_src; e.err = 1'b1;
    sb_q.push_back(e);
  endtask

  // Inputs are already driven; check the combinational handshake, clock once,
  // then compare the registered port against the scoreboard (or held values).
  task automatic cycle();
    exp_t e;
    #1;
    check("stall", 64'(o_Stall), 64'(exp_stall));
    check("memreq", 64'(o_MemReq), 64'(exp_memreq));
    if (o_Stall) obs_stall_run++;
    if (exp_stall) m_stall_cnt++;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
    end else begin
      e.we = 1'b0; e.ad = m_ad3; e.wd = m_wd3; e.src = m_src; e.err = 1'b0;
    end
    check("we3", 64'(o_WE3), 64'(e.we));
    check("ad3", 64'(o_AD3), 64'(e.ad));
    check("wd3", 64'(o_WD3), 64'(e.wd));
    check("srcsel", 64'(o_SrcSel), 64'(e.src));
    check("memerr", 64'(o_MemErr), 64'(e.err));
`ifdef PERF_CNT_EN
    check("stallcount", 64'(o_StallCount), 64'(m_stall_cnt));
`endif
  endtask

  task automatic model_clear();
    m_ad3 = '0;
    m_wd3 = '0;
    m_src = 1'b0;
    m_stall_cnt = 0;
    sb_q.delete();
  endtask

  task automatic check_reset_outputs();
    check("rst_we3", 64'(o_WE3), 64'd0);
    check("rst_ad3", 64'(o_AD3), 64'd0);
    check("rst_wd3", 64'(o_WD3), 64'd0);
    check("rst_srcsel", 64'(o_SrcSel), 64'd0);
    check("rst_memerr", 64'(o_MemErr), 64'd0);
`ifdef PERF_CNT_EN
    check("rst_stallcount", 64'(o_StallCount), 64'd0);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_InstrValid = 1'b0; i_RegWrite = 1'b0; i_ResultSrc = 1'b0;
    i_Rd = '0; i_ALUResult = '0; i_MemValid = 1'b0; i_ReadData = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    model_clear();
    rst_n = 1'b1;
  endtask

  task automatic idle_cycle();
    i_InstrValid = 1'b0;
    i_MemValid = 1'($urandom_range(0, 1));
    i_ReadData = $urandom;
    exp_stall = 1'b0; exp_memreq = 1'b0;
    cycle();
    i_MemValid = 1'b0;
  endtask

  task automatic alu_op(input logic [AW-1:0] rd, input logic [DW-1:0] d, input logic rw);
    i_InstrValid = 1'b1; i_ResultSrc = 1'b0; i_Rd = rd; i_ALUResult = d;
    i_RegWrite = rw; i_MemValid = 1'b0;
    exp_stall = 1'b0; exp_memreq = 1'b0;
    push_wb(rw && (rd != '0), rd, d, 1'b0);
    cycle();
    i_InstrValid = 1'b0;
  endtask

  // lat = cycles from the MemReq cycle to MemValid; lat > TO never answers.
  task automatic load_op(input logic [AW-1:0] rd, input logic rw, input int lat,
                         input logic [DW-1:0] d);
    i_InstrValid = 1'b1; i_ResultSrc = 1'b1; i_Rd = rd; i_RegWrite = rw;
    i_ALUResult = $urandom; i_MemValid = 1'b0;
    exp_stall = 1'b1; exp_memreq = 1'b1;
    cycle();
    for (int k = 1; k <= TO; k++) begin
      // Issue-side noise while waiting must be ignored.
      i_InstrValid = 1'($urandom_range(0, 1));
      i_ResultSrc = 1'($urandom_range(0, 1));
      i_Rd = AW'($urandom); i_RegWrite = 1'b1; i_ALUResult = $urandom;
      exp_memreq = 1'b0;
      if (k == lat) begin
        i_MemValid = 1'b1; i_ReadData = d;
        exp_stall = 1'b0;
        push_wb(rw && (rd != '0), rd, d, 1'b1);
        cycle();
        break;
      end
      i_MemValid = 1'b0; i_ReadData = $urandom;
      exp_stall = 1'b1;
      if (k == TO) push_err();
      cycle();
    end
    i_MemValid = 1'b0;
    i_InstrValid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    exp_stall = 1'b0; exp_memreq = 1'b0;
    obs_stall_run = 0;
    @(posedge clk);
    #1;
    do_reset();
    idle_cycle();

    obs_stall_run = 0;
    alu_op(5'd5, 32'h0000_1234, 1'b1);
    check("alu_no_stall", 64'(obs_stall_run), 64'd0);

    obs_stall_run = 0;
    load_op(5'd7, 1'b1, 3, 32'hCAFE_F00D);
    check("load_stall_cycles", 64'(obs_stall_run), 64'd3);

    alu_op(5'd0, 32'hDEAD_BEEF, 1'b1);
    load_op(5'd0, 1'b1, 2, 32'h5555_AAAA);
    alu_op(5'd9, 32'h0BAD_0BAD, 1'b0);
    idle_cycle();

    obs_stall_run = 0;
    load_op(5'd3, 1'b1, TO + 5, 32'h0);
    check("timeout_stall_cycles", 64'(obs_stall_run), 64'(TO + 1));
    alu_op(5'd11, 32'h1111_2222, 1'b1);

    load_op(5'd4, 1'b1, TO, 32'hFEED_FACE);
    load_op(5'd6, 1'b1, 1, 32'h0123_4567);
    load_op(5'd8, 1'b0, 2, 32'h89AB_CDEF);

    for (int i = 1; i <= 6; i++) alu_op(AW'(i * 3), $urandom, 1'b1);

    // Reset in the middle of a wait; the late response must be dropped.
    i_InstrValid = 1'b1; i_ResultSrc = 1'b1; i_Rd = 5'd12; i_RegWrite = 1'b1;
    exp_stall = 1'b1; exp_memreq = 1'b1;
    cycle();
    i_InstrValid = 1'b0;
    exp_memreq = 1'b0;
    cycle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs();
    model_clear();
    rst_n = 1'b1;
    i_MemValid = 1'b1; i_ReadData = 32'h7777_7777;
    exp_stall = 1'b0; exp_memreq = 1'b0;
    cycle();
    i_MemValid = 1'b0;
    alu_op(5'd13, 32'h2468_ACE0, 1'b1);

`ifdef PERF_CNT_EN
    do_reset();
    load_op(5'd1, 1'b1, 2, 32'hAAAA_0001);
    load_op(5'd2, 1'b1, 4, 32'hAAAA_0002);
    check("stallcount_two_loads", 64'(o_StallCount), 64'd6);
`endif

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: idle_cycle();
        1, 2: alu_op(AW'($urandom), $urandom, 1'($urandom_range(0, 1)));
        default: load_op(AW'($urandom), 1'($urandom_range(0, 1)),
                         int'($urandom_range(1, TO + 2)), $urandom);
      endcase
    end
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
